// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg #(
   parameter int unsigned       DATA_W     = 64,
   parameter logic [DATA_W-1:0] RESET_DATA = {32'h0000_3000, 32'h0000_0000}
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] or_data,
   output logic              o_full
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [31:0]       o_stall_cnt,
   output logic [31:0]       o_xfer_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t              state, state_nxt;
   logic                ready_q;
   logic [DATA_W-1:0]   skid_data;
   logic [DATA_W-1:0]   data_nxt, skid_nxt;
   logic                skid_valid;
   logic                accept, xfer;

   assign o_valid    = (state != EMPTY);
   assign skid_valid = (state == FULL);
   assign o_full     = skid_valid;
   assign o_ready    = ready_q;

   assign accept = i_valid & ready_q;
   assign xfer   = o_valid & i_ready;

   always_comb begin
      state_nxt = state;
      data_nxt  = or_data;
      skid_nxt  = skid_data;
      if (i_flush) begin
         // Squash wins over any beat accepted this cycle.
         state_nxt = EMPTY;
         data_nxt  = RESET_DATA;
         skid_nxt  = RESET_DATA;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  data_nxt  = i_data;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  data_nxt = i_data;
               end else if (accept) begin
                  state_nxt = FULL;
                  skid_nxt  = i_data;
               end else if (xfer) begin
                  state_nxt = EMPTY;
                  data_nxt  = RESET_DATA;
               end
            end
            FULL: begin
               if (xfer) begin
                  state_nxt = ONE;
                  data_nxt  = skid_data;
                  skid_nxt  = RESET_DATA;
               end
            end
            default: begin
               state_nxt = EMPTY;
               data_nxt  = RESET_DATA;
               skid_nxt  = RESET_DATA;
            end
         endcase
      end
   end

   // Ready is registered from the next state so i_ready never reaches o_ready combinationally.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         or_data   <= RESET_DATA;
         skid_data <= RESET_DATA;
      end else begin
         state     <= state_nxt;
         ready_q   <= (state_nxt != FULL);
         or_data   <= data_nxt;
         skid_data <= skid_nxt;
      end
   end

`ifdef PIPE_SKID_PERF_EN
   // Saturating counters; flush deliberately leaves them alone.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_xfer_cnt  <= '0;
      end else begin
         if (o_valid && !i_ready && (o_stall_cnt != 32'hFFFF_FFFF))
            o_stall_cnt <= o_stall_cnt + 32'd1;
         if (xfer && (o_xfer_cnt != 32'hFFFF_FFFF))
            o_xfer_cnt <= o_xfer_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model plus directed scenarios.
// Counter checks are compiled in when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_reg;

   localparam int unsigned DW  = 64;
   localparam logic [63:0] RST = {32'h0000_3000, 32'h0000_0000};

   logic          i_clk   = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_flush = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic          o_ready, o_valid, o_full;
   logic [DW-1:0] or_data;
`ifdef PIPE_SKID_PERF_EN
   logic [31:0]   o_stall_cnt, o_xfer_cnt;
`endif

   pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(RST)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_flush),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .or_data (or_data),
      .o_full  (o_full)
`ifdef PIPE_SKID_PERF_EN
      ,
      .o_stall_cnt (o_stall_cnt),
      .o_xfer_cnt  (o_xfer_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int            n_chk  = 0;
   int            n_pass = 0;
   bit            chk_en = 1'b0;
   logic [DW-1:0] mq[$];
   logic [DW-1:0] deliv[$];
   longint        m_stall = 0;
   longint        m_xfer  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: the stage is a FIFO of depth 2 viewed from outside.
   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         mq.delete();
         m_stall = 0;
         m_xfer  = 0;
      end else begin
         bit acc, xf;
         acc = i_valid && (mq.size() < 2);
         xf  = (mq.size() > 0) && i_ready;
         if ((mq.size() > 0) && !i_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (xf && m_xfer < 64'hFFFF_FFFF) m_xfer++;
         if (i_flush) mq.delete();
         else begin
            if (xf) void'(mq.pop_front());
            if (acc) mq.push_back(i_data);
         end
      end
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         check("m_valid", {63'd0, o_valid}, {63'd0, mq.size() > 0});
         check("m_data",  or_data, (mq.size() > 0) ? mq[0] : RST);
         check("m_full",  {63'd0, o_full},  {63'd0, mq.size() == 2});
         check("m_ready", {63'd0, o_ready}, {63'd0, mq.size() < 2});
         check("invariant", {63'd0, o_full & ~o_valid}, 64'd0);
`ifdef PIPE_SKID_PERF_EN
         check("m_stall", {32'd0, o_stall_cnt}, m_stall);
         check("m_xfer",  {32'd0, o_xfer_cnt},  m_xfer);
`endif
         if (!i_reset && o_valid && i_ready) deliv.push_back(or_data);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      cyc(2);
      check("rst_valid", {63'd0, o_valid}, 64'd0);
      check("rst_ready", {63'd0, o_ready}, 64'd1);
      check("rst_full",  {63'd0, o_full},  64'd0);
      check("rst_data",  or_data, RST);
      i_reset = 1'b0;
      cyc(1);
      deliv.delete();
   endtask

   initial begin
      #1 i_reset = 1'b1;
      chk_en = 1'b1;
      @(posedge i_clk);
      #1;
      do_reset();

      // 1: single beat, one-cycle latency
      i_valid = 1'b1; i_data = 64'h0000_0000_3000_AAAA; i_ready = 1'b1;
      check("t1_ready_pre", {63'd0, o_ready}, 64'd1);
      cyc(1);
      check("t1_valid", {63'd0, o_valid}, 64'd1);
      check("t1_data",  or_data, 64'h0000_0000_3000_AAAA);
      check("t1_ready", {63'd0, o_ready}, 64'd1);
      i_valid = 1'b0;
      cyc(2);

      // 2: back-pressure fills the skid, then drain in order
      do_reset();
      i_ready = 1'b0; i_valid = 1'b1; i_data = 64'hD000_0000_0000_0000;
      cyc(1);
      i_data = 64'hD000_0000_0000_0001;
      cyc(1);
      i_data = 64'hD000_0000_0000_0002;
      cyc(2);
      check("t2_full",  {63'd0, o_full},  64'd1);
      check("t2_ready", {63'd0, o_ready}, 64'd0);
      check("t2_data",  or_data, 64'hD000_0000_0000_0000);
      i_ready = 1'b1;
      cyc(1);
      check("t2_data1", or_data, 64'hD000_0000_0000_0001);
      cyc(1);
      i_data = 64'hD000_0000_0000_0003;
      cyc(1);
      i_valid = 1'b0;
      cyc(3);
      check("t2_count", deliv.size(), 64'd4);
      for (int k = 0; k < 4; k++)
         check("t2_order", (k < deliv.size()) ? deliv[k] : 64'hX, 64'hD000_0000_0000_0000 | k);

      // 3: flush from FULL and from ONE discards the incoming beat
      do_reset();
      i_valid = 1'b1; i_data = 64'hD000_0000_0000_0007;
      cyc(1);
      i_data = 64'hD000_0000_0000_0008;
      cyc(1);
      i_flush = 1'b1; i_data = 64'hD000_0000_0000_0009;
      cyc(1);
      i_flush = 1'b0; i_valid = 1'b0;
      check("t3_valid", {63'd0, o_valid}, 64'd0);
      check("t3_full",  {63'd0, o_full},  64'd0);
      check("t3_data",  or_data, RST);
      check("t3_ready", {63'd0, o_ready}, 64'd1);
      i_valid = 1'b1; i_data = 64'hD000_0000_0000_0006;
      cyc(1);
      i_flush = 1'b1; i_data = 64'hD000_0000_0000_0009;
      cyc(1);
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      cyc(3);
      check("t3_no_d9_valid", {63'd0, o_valid}, 64'd0);
      check("t3_no_delivery", deliv.size(), 64'd0);

      // 4: asynchronous reset while FULL
      do_reset();
      i_valid = 1'b1; i_data = 64'hD000_0000_0000_0007;
      cyc(1);
      i_data = 64'hD000_0000_0000_0008;
      cyc(1);
      i_valid = 1'b0;
      check("t4_full_pre", {63'd0, o_full}, 64'd1);
      #2 i_reset = 1'b1;
      #1;
      check("t4_valid", {63'd0, o_valid}, 64'd0);
      check("t4_full",  {63'd0, o_full},  64'd0);
      check("t4_data",  or_data, RST);
      check("t4_ready", {63'd0, o_ready}, 64'd1);
      cyc(1);
      i_reset = 1'b0;
      cyc(1);

      // 5: ONE with simultaneous accept and transfer
      i_ready = 1'b1; i_valid = 1'b1; i_data = 64'hD000_0000_0000_0004;
      cyc(1);
      i_data = 64'hD000_0000_0000_0005;
      cyc(1);
      check("t5_valid", {63'd0, o_valid}, 64'd1);
      check("t5_data",  or_data, 64'hD000_0000_0000_0005);
      check("t5_full",  {63'd0, o_full}, 64'd0);
      i_valid = 1'b0;
      cyc(2);

`ifdef PIPE_SKID_PERF_EN
      // 6: three stall cycles then four transfers; flush keeps the counts
      do_reset();
      check("t6_stall0", {32'd0, o_stall_cnt}, 64'd0);
      check("t6_xfer0",  {32'd0, o_xfer_cnt},  64'd0);
      i_valid = 1'b1; i_data = 64'hE000_0000_0000_0000;
      cyc(1);
      i_valid = 1'b0;
      cyc(3);
      i_ready = 1'b1; i_valid = 1'b1; i_data = 64'hE000_0000_0000_0001;
      cyc(1);
      i_data = 64'hE000_0000_0000_0002;
      cyc(1);
      i_data = 64'hE000_0000_0000_0003;
      cyc(1);
      i_valid = 1'b0;
      cyc(1);
      check("t6_stall", {32'd0, o_stall_cnt}, 64'd3);
      check("t6_xfer",  {32'd0, o_xfer_cnt},  64'd4);
      i_flush = 1'b1;
      cyc(1);
      i_flush = 1'b0;
      check("t6_stall_flush", {32'd0, o_stall_cnt}, 64'd3);
      check("t6_xfer_flush",  {32'd0, o_xfer_cnt},  64'd4);
      cyc(1);
`endif

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-width, enable-only stage registers (F/D, D/E, ...). Upstream can be back-pressured without a combinational ready path, and downstream sees a clean valid bit with a programmable bubble value. It sits between any two pipeline stages; flush squashes in-flight contents to the bubble.

Parameters:
DATA_W, 64, payload width (e.g. {pc, instr}).
RESET_DATA, {32'h0000_3000, 32'h0000_0000}, bubble payload driven whenever the stage is empty (PC default / nop); width DATA_W.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_flush  in  1  synchronous squash of all held entries.
i_valid  in  1  upstream presents i_data.
o_ready  out  1  registered; stage can accept this cycle.
i_data  in  DATA_W  upstream payload.
o_valid  out  1  or_data holds a live entry.
i_ready  in  1  downstream accepts this cycle.
or_data  out  DATA_W  registered payload to next stage.
o_full  out  1  skid entry occupied (debug / hazard unit).

Behaviour:
- Storage: main entry (or_data, o_valid) and skid entry (skid_data, skid_valid). o_ready = ~skid_valid, driven straight from a flop; no combinational path from i_ready.
- Accept: i_valid & o_ready. Transfer out: o_valid & i_ready.
- States:
  - EMPTY: o_valid=0, skid_valid=0.
  - ONE: o_valid=1, skid_valid=0.
  - FULL: o_valid=1, skid_valid=1.
- Transitions, per rising edge, when i_flush=0:
  - EMPTY + accept -> ONE: or_data<=i_data.
  - EMPTY, no accept -> stays EMPTY; or_data holds RESET_DATA.
  - ONE + accept + transfer -> ONE: or_data<=i_data.
  - ONE + accept, no transfer -> FULL: skid_data<=i_data, or_data unchanged.
  - ONE + transfer, no accept -> EMPTY: or_data<=RESET_DATA.
  - ONE, neither -> hold.
  - FULL + transfer -> ONE: or_data<=skid_data, skid_data<=RESET_DATA. No accept is possible in FULL because o_ready=0.
  - FULL, no transfer -> hold.
- Ordering: entries leave in arrival order; no drop, no duplication.
- Latency: 1 cycle from accept to o_valid when EMPTY or ONE-with-transfer. Sustained throughput 1 entry/cycle while i_ready=1.
- Flush (i_flush=1): next edge forces EMPTY. o_valid, skid_valid <= 0; or_data, skid_data <= RESET_DATA; o_ready <= 1. Flush beats a simultaneous accept; the input beat is discarded. Upstream must not treat a beat accepted during flush as delivered.
- Reset: asynchronous and active-high, reset is one clock, i_reset, asynchronous active-high. While asserted:
  - o_valid=0, skid_valid=0, o_full=0, o_ready=1.
  - or_data=RESET_DATA, skid_data=RESET_DATA.
  - Reset mid-FULL discards both entries.
- Invariant: skid_valid=1 implies o_valid=1. Verification asserts this every cycle.
- No X propagation: or_data always equals RESET_DATA when o_valid=0.

Optional Feature:
Macro PIPE_SKID_PERF_EN.
- With it: two extra outputs o_stall_cnt[31:0] and o_xfer_cnt[31:0].
  - o_stall_cnt counts cycles with o_valid & ~i_ready.
  - o_xfer_cnt counts transfers out.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by i_reset, not by flush.
- Without it: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then i_valid=1 with i_data=0x3000_AAAA and i_ready=1 held -> o_valid=1 the next cycle with or_data=0x3000_AAAA; o_ready stays 1 throughout.
2. Stream D0..D3 with i_ready=0 from cycle 1 -> accept D0, D1, then o_ready=0 and o_full=1; or_data=D0. Release i_ready -> D0, D1, D2, D3 delivered in order, none lost.
3. FULL state, i_flush=1 with i_valid=1 (D9) -> next cycle o_valid=0, o_full=0, or_data=RESET_DATA, o_ready=1; D9 never appears.
4. Assert i_reset asynchronously mid-cycle while FULL -> o_valid, o_full drop immediately with no clock edge; or_data=RESET_DATA.
5. ONE state, simultaneous accept (D5) and transfer -> stays ONE, or_data=D5, o_full=0.
6. PIPE_SKID_PERF_EN: 3 stalled cycles, then 4 transfers -> o_stall_cnt=3, o_xfer_cnt=4. A following flush leaves both unchanged.
